if_fetch: RTL and testbench

- IF-stage fetch unit. Owns the PC and runs a single-outstanding request/ack handshake to the instruction bus.
- Presents the fetched pair (if_pc, if_inst) to the IF/ID pipeline register.
- Raises stallreq to the stall controller while no instruction is ready.
- Accepts delayed-branch redirects from ID and exception/flush redirects from the controller.

---
 rtl/if_fetch.sv | 161 ++++++++++++++++
 tb/tb_if_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// IF-stage fetch unit: owns the PC and runs a single-outstanding request/ack
// handshake to the instruction bus, handing (if_pc, if_inst) to IF/ID.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_data_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_target_q, redirect_target_d;
  logic        discard_q, discard_d;
  logic        bus_req_q, bus_req_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic        branch_capture;
  logic [31:0] next_pc;
  logic        unused_stall_bits;

  assign unused_stall_bits = ^{stall[5:3], stall[1]};

  assign branch_capture = branch_flag_i && !stall[2];
  // A captured branch only takes effect when the delay-slot instruction is consumed.
  assign next_pc = redirect_valid_q ? redirect_target_q : pc_q + 32'd4;

  assign stallreq   = (state_q != S_DONE) && !rst;
  assign bus_req_o  = bus_req_q;
  assign bus_addr_o = bus_addr_q;
  assign if_pc      = if_pc_q;
  assign if_inst    = if_inst_q;

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    redirect_valid_d  = redirect_valid_q;
    redirect_target_d = redirect_target_q;
    discard_d         = discard_q;
    bus_req_d         = bus_req_q;
    bus_addr_d        = bus_addr_q;
    if_pc_d           = if_pc_q;
    if_inst_d         = if_inst_q;

    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          pc_d             = new_pc;
          redirect_valid_d = 1'b0;
        end else begin
          bus_req_d  = 1'b1;
          bus_addr_d = pc_q;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        if (bus_ack_i) begin
          bus_req_d = 1'b0;
          if (discard_q || flush) begin
            discard_d = 1'b0;
            state_d   = S_IDLE;
            if (flush) begin
              pc_d             = new_pc;
              redirect_valid_d = 1'b0;
            end
          end else begin
            if_pc_d   = pc_q;
            if_inst_d = bus_data_i;
            state_d   = S_DONE;
          end
        end else if (flush) begin
          // The bus transaction cannot be withdrawn; let it finish and drop its data.
          pc_d             = new_pc;
          discard_d        = 1'b1;
          redirect_valid_d = 1'b0;
        end
      end

      S_DONE: begin
        if (flush) begin
          if_pc_d          = 32'd0;
          if_inst_d        = 32'd0;
          pc_d             = new_pc;
          redirect_valid_d = 1'b0;
          state_d          = S_IDLE;
        end else if (!stall[0]) begin
          pc_d             = next_pc;
          redirect_valid_d = 1'b0;
          if_pc_d          = 32'd0;
          if_inst_d        = 32'd0;
          bus_req_d        = 1'b1;
          bus_addr_d       = next_pc;
          state_d          = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Applied after the state logic so a capture survives a same-edge consumption.
    if (branch_capture && !flush) begin
      redirect_valid_d  = 1'b1;
      redirect_target_d = branch_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      pc_q              <= RESET_PC;
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= 32'd0;
      discard_q         <= 1'b0;
      bus_req_q         <= 1'b0;
      bus_addr_q        <= 32'd0;
      if_pc_q           <= 32'd0;
      if_inst_q         <= 32'd0;
    end else begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      redirect_valid_q  <= redirect_valid_d;
      redirect_target_q <= redirect_target_d;
      discard_q         <= discard_d;
      bus_req_q         <= bus_req_d;
      bus_addr_q        <= bus_addr_d;
      if_pc_q           <= if_pc_d;
      if_inst_q         <= if_inst_d;
    end
  end

  // Handshake invariants: request/address hold until ack, bus idles after every ack.
  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (bus_req_o && !bus_ack_i) |=> (bus_req_o && $stable(bus_addr_o)));

  a_idle_after_ack: assert property (@(posedge clk) disable iff (rst)
    (bus_req_o && bus_ack_i) |=> !bus_req_o);

endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch: a transaction-level model predicts
// bus addresses and delivered (pc, inst) pairs; a negedge monitor checks them.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          N_CYCLES = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = 6'd0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = 32'd0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'd0;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_data_i = 32'd0;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .bus_req_o      (bus_req_o),
    .bus_addr_o     (bus_addr_o),
    .bus_ack_i      (bus_ack_i),
    .bus_data_i     (bus_data_i),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .stallreq       (stallreq)
  );

  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  item_t       sb_q[$];
  bit          tb_done = 1'b0;

  // Reference model: what has been requested, what is held, what redirect is pending.
  bit          m_in_flight = 1'b0;
  bit          m_stale = 1'b0;
  bit          m_holding = 1'b0;
  bit          m_pend = 1'b0;
  bit          m_rst_seen = 1'b0;
  logic [31:0] m_fetch_addr = RESET_PC;
  logic [31:0] m_req_addr = 32'd0;
  logic [31:0] m_pend_target = 32'd0;
  logic [31:0] m_held_pc = 32'd0;
  int          n_delivered = 0;

  always @(posedge clk) begin
    bit          cap;
    logic [31:0] nxt;
    item_t       it;
    cap        = branch_flag_i && !stall[2] && !flush;
    m_rst_seen = rst;
    if (rst) begin
      m_in_flight  = 1'b0;
      m_stale      = 1'b0;
      m_holding    = 1'b0;
      m_pend       = 1'b0;
      m_fetch_addr = RESET_PC;
      sb_q.delete();
    end else begin
      if (m_holding) begin
        if (flush) begin
          m_holding    = 1'b0;
          m_fetch_addr = new_pc;
          m_pend       = 1'b0;
        end else if (!stall[0]) begin
          nxt         = m_pend ? m_pend_target : m_held_pc + 32'd4;
          m_pend      = 1'b0;
          m_holding   = 1'b0;
          m_in_flight = 1'b1;
          m_req_addr  = nxt;
        end
      end else if (m_in_flight) begin
        if (bus_ack_i) begin
          m_in_flight = 1'b0;
          if (flush) begin
            m_stale      = 1'b0;
            m_fetch_addr = new_pc;
            m_pend       = 1'b0;
          end else if (m_stale) begin
            m_stale = 1'b0;
          end else begin
            m_holding = 1'b1;
            m_held_pc = m_req_addr;
            it.pc     = m_req_addr;
            it.inst   = mem_word(m_req_addr);
            sb_q.push_back(it);
            n_delivered++;
          end
        end else if (flush) begin
          m_stale      = 1'b1;
          m_fetch_addr = new_pc;
          m_pend       = 1'b0;
        end
      end else begin
        if (flush) begin
          m_fetch_addr = new_pc;
          m_pend       = 1'b0;
        end else begin
          m_in_flight = 1'b1;
          m_req_addr  = m_fetch_addr;
        end
      end
      if (cap) begin
        m_pend        = 1'b1;
        m_pend_target = branch_target_i;
      end
    end
  end

  // Monitor / scoreboard checker.
  int    n_checks = 0;
  int    n_fail = 0;
  bit    prev_present = 1'b0;
  item_t cur;

  always @(negedge clk) begin
    bit    present;
    bit    exp_stallreq;
    item_t it;
    if (tb_done) begin
      n_checks++;
      if (sb_q.size() != 0) begin
        n_fail++;
        $display("FAIL sb_drain: %0d undelivered entries, required 0", sb_q.size());
      end
      n_checks++;
      if (n_delivered < 100) begin
        n_fail++;
        $display("FAIL throughput: %0d deliveries, required at least 100", n_delivered);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end else begin
      present      = !rst && !stallreq;
      exp_stallreq = !rst && !m_holding;

      n_checks++;
      if (stallreq !== exp_stallreq) begin
        n_fail++;
        $display("FAIL stallreq: got %b required %b at %0t", stallreq, exp_stallreq, $time);
      end

      n_checks++;
      if (bus_req_o !== m_in_flight || (m_in_flight && bus_addr_o !== m_req_addr)) begin
        n_fail++;
        $display("FAIL bus_req: got req=%b addr=%h required req=%b addr=%h at %0t",
                 bus_req_o, bus_addr_o, m_in_flight, m_req_addr, $time);
      end

      if (m_rst_seen) begin
        n_checks++;
        if (bus_req_o !== 1'b0 || bus_addr_o !== 32'd0 || if_pc !== 32'd0 || if_inst !== 32'd0) begin
          n_fail++;
          $display("FAIL reset_state: got req=%b addr=%h pc=%h inst=%h required all zero",
                   bus_req_o, bus_addr_o, if_pc, if_inst);
        end
      end else if (present && !prev_present) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL fetch_data: got pc=%h inst=%h with no delivery expected", if_pc, if_inst);
        end else begin
          it  = sb_q.pop_front();
          cur = it;
          if (if_pc !== it.pc || if_inst !== it.inst) begin
            n_fail++;
            $display("FAIL fetch_data: got pc=%h inst=%h required pc=%h inst=%h",
                     if_pc, if_inst, it.pc, it.inst);
          end else begin
            $display("fetch pc=%h inst=%h t=%0t", if_pc, if_inst, $time);
          end
        end
      end else if (present) begin
        n_checks++;
        if (if_pc !== cur.pc || if_inst !== cur.inst) begin
          n_fail++;
          $display("FAIL held_data: got pc=%h inst=%h required pc=%h inst=%h",
                   if_pc, if_inst, cur.pc, cur.inst);
        end
      end else if (!rst) begin
        n_checks++;
        if (if_pc !== 32'd0 || if_inst !== 32'd0) begin
          n_fail++;
          $display("FAIL empty_data: got pc=%h inst=%h required zero", if_pc, if_inst);
        end
      end
      prev_present = present;
    end
  end

  // Stimulus and bus slave: zero-wait phase, then random waits/stalls, then branches, then flush/reset.
  initial begin
    bit zero_wait;
    bit use_stall;
    bit use_branch;
    bit use_flush;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      zero_wait  = (cyc < 40);
      use_stall  = (cyc >= 40);
      use_branch = (cyc >= 400);
      use_flush  = (cyc >= 700);
      rst = use_flush && (($urandom_range(0, 149) == 0) ||
                          (bus_req_o && $urandom_range(0, 59) == 0));
      stall = use_stall ? 6'($urandom) : 6'd0;
      if (!use_branch) stall[2] = 1'b0;
      flush  = use_flush && ($urandom_range(0, 11) == 0);
      new_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_0FFC);
      branch_flag_i   = use_branch && ($urandom_range(0, 3) == 0);
      branch_target_i = $urandom & 32'h0000_3FFC;
      bus_ack_i  = bus_req_o && (zero_wait || $urandom_range(0, 2) == 0);
      bus_data_i = mem_word(bus_addr_o);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    flush = 1'b0;
    branch_flag_i = 1'b0;
    bus_ack_i = 1'b0;
    tb_done = 1'b1;
  end

endmodule
